lab3_restoring_divider_4_bit: RTL and testbench



---
 rtl/lab3_div_pkg.sv | 12 +
 rtl/lab3_borrow_sub_n.sv | 27 ++
 rtl/lab3_restoring_divider_4_bit.sv | 123 ++++++++++++
 tb/tb_lab3_restoring_divider_4_bit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lab3_div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package lab3_div_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/lab3_borrow_sub_n.sv
// Parameterised ripple-borrow subtractor: Diff = X - Y - Bin, Bout is the borrow out of the MSB.
module lab3_borrow_sub_n #(
    parameter int N = 5
) (
    output logic [N-1:0] Diff,
    output logic         Bout,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         Bin
);

    logic [N:0] b;

    assign b[0] = Bin;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            assign Diff[i]  = X[i] ^ Y[i] ^ b[i];
            // Borrow when X < Y, or X == Y with an incoming borrow.
            assign b[i+1]   = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & b[i]);
        end
    endgenerate

    assign Bout = b[N];

endmodule

// File: rtl/lab3_restoring_divider_4_bit.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, start/done handshake.
// Optional feature: define DIV_ZERO_CHECK_EN to short-circuit zero divisors and flag them on div_zero.
module lab3_restoring_divider_4_bit
    import lab3_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e       state, state_nxt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   diff;
    logic             bout;
    logic             zero_hit;
    logic             last_iter;

    // Shift the partial remainder left and bring in the next dividend bit.
    assign t         = (r_reg << 1) | (WIDTH + 1)'(q_reg[WIDTH-1]);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    lab3_borrow_sub_n #(.N(WIDTH + 1)) u_sub (
        .Diff (diff),
        .Bout (bout),
        .X    (t),
        .Y    ({1'b0, d_reg}),
        .Bin  (1'b0)
    );

`ifdef DIV_ZERO_CHECK_EN
    logic div_zero_r;

    assign zero_hit = (divisor == '0);
    assign div_zero = div_zero_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_zero_r <= 1'b0;
        end else if (state == IDLE && start) begin
            div_zero_r <= zero_hit;
        end
    end
`else
    assign zero_hit = 1'b0;
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_hit ? DONE : RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        d_reg <= divisor;
                        if (zero_hit) begin
                            // Same values the full algorithm would reach with D = 0.
                            q_reg <= '1;
                            r_reg <= {1'b0, dividend};
                        end else begin
                            q_reg <= dividend;
                            r_reg <= '0;
                        end
                    end
                end
                RUN: begin
                    r_reg <= bout ? t : diff;
                    q_reg <= {q_reg[WIDTH-2:0], ~bout};
                    cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    quotient  <= q_reg;
                    remainder <= r_reg[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_lab3_restoring_divider_4_bit.sv
// Directed table-driven bench for the 4-bit restoring divider, plus busy, reset and zero-divisor sequences.
module tb_lab3_restoring_divider_4_bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    int n_chk  = 0;
    int n_fail = 0;

    lab3_restoring_divider_4_bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] a;
        logic [3:0] b;
        int         q;
        int         r;
        int         lat;
        int         dz;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Entered #1 after a rising edge with the DUT idle; leaves it idle the same way.
    task automatic run_div(input vec_t v);
        int lat;
        lat      = 0;
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        chk({v.nm, "_busy"}, int'(busy), (v.lat > 1) ? 1 : 0);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                chk({v.nm, "_q"}, int'(quotient), v.q);
                chk({v.nm, "_r"}, int'(remainder), v.r);
                chk({v.nm, "_dz"}, int'(div_zero), v.dz);
                chk({v.nm, "_busy_at_done"}, int'(busy), 0);
            end
        end
        chk({v.nm, "_latency"}, lat, v.lat);
        @(posedge clk); #1;
        chk({v.nm, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int   ndone;
        int   nbusy;
        int   lat;
        int   cq;
        int   cr;
        vec_t v;

        vecs[0] = '{"12div5", 4'd12, 4'd5, 2, 2, 5, 0};
        vecs[1] = '{"13div6", 4'd13, 4'd6, 2, 1, 5, 0};
        vecs[2] = '{"15div1", 4'd15, 4'd1, 15, 0, 5, 0};
        vecs[3] = '{"3div9", 4'd3, 4'd9, 0, 3, 5, 0};
        vecs[4] = '{"9div9", 4'd9, 4'd9, 1, 0, 5, 0};
        vecs[5] = '{"5div5", 4'd5, 4'd5, 1, 0, 5, 0};
        vecs[6] = '{"15div4", 4'd15, 4'd4, 3, 3, 5, 0};
`ifdef DIV_ZERO_CHECK_EN
        vecs[7] = '{"7div0", 4'd7, 4'd0, 15, 7, 1, 1};
`else
        vecs[7] = '{"7div0", 4'd7, 4'd0, 15, 7, 5, 0};
`endif

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dz", int'(div_zero), 0);
        rst_n = 1'b1;

        nbusy = 0;
        ndone = 0;
        repeat (10) begin
            @(posedge clk); #1;
            nbusy += int'(busy);
            ndone += int'(done);
        end
        chk("idle_busy_cycles", nbusy, 0);
        chk("idle_done_cycles", ndone, 0);

        foreach (vecs[i]) run_div(vecs[i]);

        // Start pulses while busy must be ignored, operand changes too.
        dividend = 4'd6;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        lat   = 0;
        cq    = -1;
        cr    = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                lat = k;
                cq  = int'(quotient);
                cr  = int'(remainder);
            end
            if (k == 1) begin
                start    = 1'b1;
                dividend = 4'd15;
                divisor  = 4'd2;
            end
            if (k == 3) start = 1'b0;
        end
        chk("busy_ign_ndone", ndone, 1);
        chk("busy_ign_lat", lat, 5);
        chk("busy_ign_q", cq, 1);
        chk("busy_ign_r", cr, 2);

        // Reset during the second iteration aborts the operation.
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_q", int'(quotient), 0);
        chk("midrst_r", int'(remainder), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            ndone += int'(done);
        end
        chk("midrst_no_done", ndone, 0);

        v = '{"14div3", 4'd14, 4'd3, 4, 2, 5, 0};
        run_div(v);

        // Back-to-back: held start re-triggers immediately after the done cycle.
        dividend = 4'd11;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        lat   = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (done && lat == 0) lat = k;
        end
        chk("b2b_first_lat", lat, 5);
        chk("b2b_retrigger_busy", int'(busy), 1);
        start = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
        end
        chk("b2b_second_lat", lat, 5);
        chk("b2b_q", int'(quotient), 3);
        chk("b2b_r", int'(remainder), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
